// File: rtl/note_disp_pkg.sv
// Shared glyph table and decoder types for the note display encoder/decoder pair.
// Index into SEG_TABLE is {TOM, NOTAS}; patterns are {a,b,c,d,e,f,g}, active-high.
package note_disp_pkg;

   localparam int NOTE_W = 3;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Upper-case glyphs for TOM=0, lower-case/alternate glyphs for TOM=1.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1001110,  // 0  C
      7'b0111101,  // 1  d
      7'b1001111,  // 2  E
      7'b1000111,  // 3  F
      7'b1011110,  // 4  G
      7'b1110111,  // 5  A
      7'b0011111,  // 6  b
      7'b0000001,  // 7  -
      7'b0001101,  // 8  c
      7'b0111110,  // 9  U
      7'b0001110,  // 10 L
      7'b1100111,  // 11 P
      7'b0000101,  // 12 r
      7'b0010101,  // 13 n
      7'b0011101,  // 14 o
      7'b0001000   // 15 _
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/seg_note_decoder_lookup.sv
// Combinational reverse lookup of a segment pattern into the glyph table.
// Lowest matching index wins.
module seg_lookup
   import note_disp_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic [3:0] idx
);

   always_comb begin
      hit = 1'b0;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (seg == SEG_TABLE[i]) begin
            hit = 1'b1;
            idx = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg_note_decoder.sv
// Debounces a 7-segment pattern and recovers {TOM, NOTAS} as valid/ready note events.
// Optional macro SEG_NOTE_DEC_REPEAT_EN enables auto-repeat of a held note.
module seg_note_decoder
   import note_disp_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int REPEAT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        SEG_IN,
   input  logic              NOTE_READY,
   output logic              NOTE_VALID,
   output logic              TOM_OUT,
   output logic [NOTE_W-1:0] NOTAS_OUT,
   output logic              ERR,
   output logic              OVR
);

   localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   state_t     state;
   logic [6:0] smp_p0;
   logic [6:0] last_p0;
   logic [CNT_W-1:0] cnt_p0;

   logic       changed;
   logic       accept;
   logic       hit;
   logic [3:0] idx;
   logic       new_ev;
   logic       miss;
   logic       ev;

   seg_lookup u_lookup (
      .seg (smp_p0),
      .hit (hit),
      .idx (idx)
   );

   assign changed = (SEG_IN != smp_p0);
   assign accept  = (state == SETTLE) && !changed && (cnt_p0 == CNT_MAX);
   assign new_ev  = accept && (smp_p0 != SEG_BLANK) && (smp_p0 != last_p0) && hit;
   assign miss    = accept && (smp_p0 != SEG_BLANK) && (smp_p0 != last_p0) && !hit;

`ifdef SEG_NOTE_DEC_REPEAT_EN
   localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rcnt_p0;
   logic             rep_fire;

   assign rep_fire = (state == LOCKED) && !changed && hit && (rcnt_p0 == REP_MAX);
   assign ev       = new_ev || rep_fire;

   // Phase is anchored to the accept edge because SETTLE holds the counter at zero.
   always_ff @(posedge clk) begin
      if (!rst_n || state != LOCKED || changed) begin
         rcnt_p0 <= '0;
      end else if (hit) begin
         rcnt_p0 <= rep_fire ? '0 : rcnt_p0 + REP_W'(1);
      end
   end
`else
   assign ev = new_ev;
`endif

   // Stage p0: sample, stability count, debounce FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         smp_p0  <= SEG_BLANK;
         last_p0 <= SEG_BLANK;
         cnt_p0  <= '0;
      end else begin
         smp_p0 <= SEG_IN;
         if (changed)                cnt_p0 <= '0;
         else if (cnt_p0 != CNT_MAX) cnt_p0 <= cnt_p0 + CNT_W'(1);
         case (state)
            IDLE:    if (changed) state <= SETTLE;
            SETTLE:  if (accept) begin
                        state   <= LOCKED;
                        last_p0 <= smp_p0;
                     end
            LOCKED:  if (changed) state <= SETTLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p1: event holding register and status flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         NOTE_VALID <= 1'b0;
         TOM_OUT    <= 1'b0;
         NOTAS_OUT  <= '0;
         ERR        <= 1'b0;
         OVR        <= 1'b0;
      end else begin
         ERR <= miss;
         if (ev) begin
            if (!NOTE_VALID || NOTE_READY) begin
               NOTE_VALID <= 1'b1;
               TOM_OUT    <= idx[3];
               NOTAS_OUT  <= idx[NOTE_W-1:0];
            end else begin
               OVR <= 1'b1;
            end
         end else if (NOTE_VALID && NOTE_READY) begin
            NOTE_VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_note_decoder.sv
// Self-checking bench for seg_note_decoder: directed scenarios plus random patterns
// against a run-length based reference model (honours SEG_NOTE_DEC_REPEAT_EN).
module tb_seg_note_decoder;
   import note_disp_pkg::*;

   localparam int STABLE = 4;
   localparam int REPEAT = 64;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg_in;
   logic       ready;
   logic       note_valid;
   logic       tom_out;
   logic [2:0] notas_out;
   logic       err;
   logic       ovr;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [6:0] m_s, m_last;
   int         m_run;
   bit         m_judged;
   bit         m_valid, m_err, m_ovr;
   logic [3:0] m_data;

   seg_note_decoder #(.STABLE_CYCLES(STABLE), .REPEAT_CYCLES(REPEAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .SEG_IN     (seg_in),
      .NOTE_READY (ready),
      .NOTE_VALID (note_valid),
      .TOM_OUT    (tom_out),
      .NOTAS_OUT  (notas_out),
      .ERR        (err),
      .OVR        (ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int find_glyph(input logic [6:0] p);
      for (int i = 0; i < 16; i++)
         if (SEG_TABLE[i] == p) return i;
      return -1;
   endfunction

   // A pattern is judged once it has been sampled STABLE+1 times in a row.
   task automatic model_step();
      bit fire = 0;
      bit miss = 0;
      int g;
      if (!rst_n) begin
         m_s = SEG_BLANK; m_last = SEG_BLANK; m_run = 1; m_judged = 1;
         m_valid = 0; m_data = 4'd0; m_err = 0; m_ovr = 0;
         return;
      end
      if (seg_in == m_s) m_run++;
      else begin
         m_s = seg_in; m_run = 1; m_judged = 0;
      end
      g = find_glyph(m_s);
      if (!m_judged && m_run == STABLE + 1) begin
         m_judged = 1;
         if (m_s != SEG_BLANK && m_s != m_last) begin
            if (g >= 0) fire = 1;
            else        miss = 1;
         end
         m_last = m_s;
      end
`ifdef SEG_NOTE_DEC_REPEAT_EN
      else if (m_judged && g >= 0 && m_run > STABLE + 1 &&
               ((m_run - STABLE - 1) % REPEAT) == 0)
         fire = 1;
`endif
      m_err = miss;
      if (m_valid && ready) m_valid = 0;
      if (fire) begin
         if (!m_valid) begin
            m_valid = 1;
            m_data  = 4'(g);
         end else begin
            m_ovr = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("valid", 32'(note_valid), 32'(m_valid));
      chk("err",   32'(err),        32'(m_err));
      chk("ovr",   32'(ovr),        32'(m_ovr));
      if (m_valid) chk("data", 32'({tom_out, notas_out}), 32'(m_data));
   endtask

   task automatic hold(input logic [6:0] p, input int n);
      seg_in = p;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int evc;
      int sel;
      int len;
      logic [6:0] p;

      // 1: reset with a valid glyph present, then no event before capture+4
      rst_n = 1'b0; seg_in = SEG_TABLE[0]; ready = 1'b1;
      tick(); tick();
      chk("rst_valid", 32'(note_valid), 32'd0);
      chk("rst_ovr",   32'(ovr),        32'd0);
      chk("rst_data",  32'({tom_out, notas_out, err}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("t1_no_early", 32'(note_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(note_valid), 32'd1);
      chk("t1_data",  32'({tom_out, notas_out}), 32'd0);
      tick();
      chk("t1_once",  32'(note_valid), 32'd0);

      // 2: blank then entry 0, one-cycle event at capture+4
      hold(SEG_BLANK, 6);
      hold(SEG_TABLE[0], 4);
      chk("t2_no_early", 32'(note_valid), 32'd0);
      tick();
      chk("t2_valid", 32'(note_valid), 32'd1);
      chk("t2_data",  32'({tom_out, notas_out}), 32'd0);
      tick();
      chk("t2_once",  32'(note_valid), 32'd0);

      // 3: short glitch on entry 3 is ignored, entry 13 decodes
      evc = 0;
      hold(SEG_TABLE[3], 2);
      seg_in = SEG_TABLE[13];
      for (int i = 0; i < 6; i++) begin
         tick();
         if (note_valid) begin
            evc++;
            chk("t3_data", 32'({tom_out, notas_out}), 32'b1101);
         end
      end
      chk("t3_events", 32'(evc), 32'd1);

      // 4: overflow while consumer stalls
      ready = 1'b0;
      hold(SEG_TABLE[0], 6);
      hold(SEG_BLANK, 6);
      hold(SEG_TABLE[8], 6);
      chk("t4_ovr",   32'(ovr),        32'd1);
      chk("t4_valid", 32'(note_valid), 32'd1);
      chk("t4_data",  32'({tom_out, notas_out}), 32'd0);
      ready = 1'b1;
      tick();
      chk("t4_drain", 32'(note_valid), 32'd0);
      chk("t4_sticky", 32'(ovr),       32'd1);

      // 5: unknown pattern pulses ERR once
      hold(7'b1111111, 4);
      chk("t5_no_early", 32'(err), 32'd0);
      tick();
      chk("t5_err", 32'(err), 32'd1);
      tick();
      chk("t5_err_pulse", 32'(err), 32'd0);
      chk("t5_no_event",  32'(note_valid), 32'd0);

      // 6: blank separates identical notes; long hold shows auto-repeat if built in
      evc = 0;
      seg_in = SEG_TABLE[0];
      for (int i = 0; i < 6; i++) begin tick(); if (note_valid) evc++; end
      seg_in = SEG_BLANK;
      for (int i = 0; i < 6; i++) begin tick(); if (note_valid) evc++; end
      seg_in = SEG_TABLE[0];
      for (int i = 0; i < 6; i++) begin tick(); if (note_valid) evc++; end
      chk("t6_two_events", 32'(evc), 32'd2);
      hold(SEG_BLANK, 6);
      evc = 0;
      seg_in = SEG_TABLE[0];
      for (int i = 0; i < 190; i++) begin tick(); if (note_valid) evc++; end
`ifdef SEG_NOTE_DEC_REPEAT_EN
      chk("t6_repeat", 32'(evc), 32'd3);
`else
      chk("t6_single", 32'(evc), 32'd1);
`endif

      // random phase from a fresh reset so OVR can be exercised again
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 150; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 5)       p = SEG_TABLE[$urandom_range(0, 15)];
         else if (sel < 7)  p = SEG_BLANK;
         else if (sel == 7) p = 7'b1111111;
         else               p = 7'($urandom);
         len = int'($urandom_range(1, 8));
         seg_in = p;
         for (int j = 0; j < len; j++) begin
            ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
